mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STREAK_MAX, default 4: max consecutive data grants while fetch waits (1..15).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clock.
REQ-004 f_req / f_addr  input  1 / 32  fetch read request; word address.
REQ-005 f_gnt / f_rvalid / f_rdata  output  1 / 1 / 32  fetch accepted pulse; read-data-valid pulse; instruction word.
REQ-006 d_req / d_we / d_addr / d_wdata / d_size  input  1 / 1 / 32 / 32 / 2  data request; 1 = store; address; store data; 00 byte, 01 half, 10 word, 11 word.
REQ-007 d_gnt / d_rvalid / d_rdata  output  1 / 1 / 32  data accepted pulse; completion pulse (load or store); load data.
REQ-008 mem_req / mem_we / mem_addr / mem_wdata / mem_size  output  1 / 1 / 32 / 32 / 2  single-port memory command.
REQ-009 mem_rvalid / mem_rdata  input  1 / 32  memory completion pulse and read data; latency L >= 1 cycles after mem_req.

Function
REQ-010 FSM states SHALL be IDLE, BUSY_F, BUSY_D; exactly one transaction outstanding at any time.
REQ-011 In IDLE with any request sampled in cycle N, the arbiter SHALL enter BUSY_F or BUSY_D at N+1 and drive mem_req plus the matching x_gnt as one-cycle registered pulses in cycle N+1.
REQ-012 Command fields (mem_addr, mem_we, mem_wdata, mem_size) SHALL be latched from the granted requester at N and held stable until completion; fetch SHALL drive mem_we=0, mem_size=10.
REQ-013 Priority: data over fetch when both requests are sampled in IDLE, subject to REQ-019.
REQ-014 Requesters SHALL hold req and fields stable until x_gnt; arbiter SHALL NOT sample requests outside IDLE.
REQ-015 On mem_rvalid in BUSY_x, the arbiter SHALL pulse x_rvalid next cycle, register x_rdata = mem_rdata (load/fetch only; d_rdata unchanged on store), and return to IDLE.
REQ-016 Total latency request-to-rvalid SHALL be L+2 cycles; a new request may be sampled in the cycle x_rvalid is high (back-to-back throughput L+2).
REQ-017 mem_rvalid in IDLE SHALL be ignored; no rvalid output, no state change.
REQ-018 x_rdata SHALL hold its last value between completions.

Reset
REQ-020 With reset=0 at a rising edge, the arbiter SHALL enter IDLE; all outputs 0 (mem_*, *_gnt, *_rvalid, *_rdata); streak counter 0.
REQ-021 Reset mid-transaction SHALL abandon the outstanding command; a late mem_rvalid after reset release SHALL be ignored per REQ-017.
REQ-022 Requests held during reset SHALL be sampled in the first cycle with reset=1.

Configuration
REQ-019 Macro ARB_STARVE_GUARD_EN: when defined, a 4-bit streak counter SHALL increment on each data grant with f_req high at sampling, clear on any fetch grant or on a data grant with f_req low; when counter == STREAK_MAX and both request, fetch SHALL be granted instead.
REQ-023 When ARB_STARVE_GUARD_EN is undefined, the counter SHALL not exist and data SHALL always win (strict priority per REQ-013).

Verification
REQ-024 Fetch only, L=1, f_addr=0x01000000 at N -> mem_req/f_gnt at N+1, mem_rvalid N+2 with 0x00000013, f_rvalid=1 and f_rdata=0x00000013 at N+3.
REQ-025 f_req and d_req (load 0x01000100, size 10) both sampled in IDLE -> d_gnt first, mem_addr=0x01000100; f_gnt at cycle after d_rvalid.
REQ-026 Store d_we=1, d_wdata=0xDEADBEEF, d_size=00 -> mem_we=1, mem_size=00, mem_wdata=0xDEADBEEF; d_rvalid pulse; d_rdata unchanged.
REQ-027 Guard enabled, STREAK_MAX=4, d_req and f_req held continuously -> grant order D,D,D,D,F,D...; guard disabled -> F never granted.
REQ-028 reset=0 one cycle during BUSY_D, then mem_rvalid arrives -> no d_rvalid, state IDLE, all outputs 0.
REQ-029 Spurious mem_rvalid in IDLE with no requests -> no f_rvalid/d_rvalid, rdata registers unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port and a data load/store port. Exactly one memory command is in flight at
// a time; data normally wins over fetch when both ask in the same cycle.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch starvation
// guard. After STREAK_MAX back-to-back data grants taken while fetch was
// waiting, the next contested arbitration goes to fetch. Without the macro,
// arbitration is strict data-over-fetch priority and no streak counter exists.
module mem_port_arbiter #(
    parameter int STREAK_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_F = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    state_t state;
    logic   take_d;
    logic   guard_fire;

    // The streak counter is 4 bits wide, so only 1..15 is meaningful.
    if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_streak_range
        $error("mem_port_arbiter: STREAK_MAX must be within 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    logic [3:0] streak;

    assign guard_fire = (streak == STREAK_LIM) && f_req && d_req;

    // Count consecutive data grants that left a fetch request waiting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            streak <= 4'd0;
        end else if (state == IDLE) begin
            if (take_d) begin
                streak <= f_req ? streak + 4'd1 : 4'd0;
            end else if (f_req) begin
                streak <= 4'd0;
            end
        end
    end
`else
    assign guard_fire = 1'b0;
`endif

    // Data wins unless the starvation guard hands this slot to fetch.
    assign take_d = d_req && !guard_fire;

    // Arbitration FSM: grant in IDLE, wait for memory completion, return data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            f_gnt     <= 1'b0;
            f_rvalid  <= 1'b0;
            f_rdata   <= 32'd0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_size  <= 2'b00;
        end else begin
            // Grants, command strobe and completions are single-cycle pulses.
            f_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            mem_req  <= 1'b0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (take_d) begin
                        state     <= BUSY_D;
                        d_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_size  <= d_size;
                    end else if (f_req) begin
                        state     <= BUSY_F;
                        f_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= f_addr;
                        mem_wdata <= 32'd0;
                        mem_size  <= 2'b10;
                    end
                end

                BUSY_F: begin
                    if (mem_rvalid) begin
                        state    <= IDLE;
                        f_rvalid <= 1'b1;
                        f_rdata  <= mem_rdata;
                    end
                end

                BUSY_D: begin
                    if (mem_rvalid) begin
                        state    <= IDLE;
                        d_rvalid <= 1'b1;
                        // Stores complete without touching the load-data register.
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors, expected commands and
// responses queued at issue time, a monitor popping and comparing them, and a
// behavioural single-port memory with programmable latency.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'd0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [1:0]  d_size = 2'b00;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        model_rvalid = 1'b0;
    logic [31:0] model_rdata = 32'd0;
    bit          model_busy = 1'b0;
    int          mem_lat = 1;
    logic        spur_rvalid = 1'b0;
    logic [31:0] spur_rdata = 32'd0;

    assign mem_rvalid = model_rvalid | spur_rvalid;
    assign mem_rdata  = model_rvalid ? model_rdata : spur_rdata;

    mem_port_arbiter #(.STREAK_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } cmd_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_f_rdata = 32'd0;
    logic [31:0] exp_d_rdata = 32'd0;
    int          last_f_gnt = 0;
    int          last_f_rv = 0;
    int          last_d_rv = 0;

    // Memory contents: one fixed instruction word, everything else ~address.
    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h0100_0000) ? 32'h0000_0013 : ~a;
    endfunction

    // Single-port memory: answers each mem_req after mem_lat cycles.
    always begin : mem_model
        logic [31:0] a;
        @(posedge clock);
        #1;
        if (mem_req) begin
            model_busy = 1'b1;
            a = mem_addr;
            repeat (mem_lat) @(posedge clock);
            #1;
            model_rvalid = 1'b1;
            model_rdata  = memval(a);
            @(posedge clock);
            #1;
            model_rvalid = 1'b0;
            model_busy   = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] a);
        cmd_t c;
        rsp_t r;
        c.is_d = 1'b0; c.we = 1'b0; c.addr = a; c.wdata = 32'd0; c.size = 2'b10;
        exp_cmd.push_back(c);
        exp_f_rdata = memval(a);
        r.is_d = 1'b0; r.rdata = exp_f_rdata;
        exp_rsp.push_back(r);
    endtask

    task automatic exp_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input bit with_rsp);
        cmd_t c;
        rsp_t r;
        c.is_d = 1'b1; c.we = we; c.addr = a; c.wdata = wd; c.size = sz;
        exp_cmd.push_back(c);
        if (with_rsp) begin
            if (!we) exp_d_rdata = memval(a);
            r.is_d = 1'b1; r.rdata = exp_d_rdata;
            exp_rsp.push_back(r);
        end
    endtask

    task automatic monitor();
        cmd_t c;
        rsp_t r;
        forever begin
            @(negedge clock);
            if (mem_req) begin
                if (exp_cmd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL cmd_unexpected: mem_req=1 addr=0x%08h, required no command", mem_addr);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_gnt", {30'd0, f_gnt, d_gnt}, c.is_d ? 32'd1 : 32'd2);
                    chk("cmd_we", {31'd0, mem_we}, {31'd0, c.we});
                    chk("cmd_addr", mem_addr, c.addr);
                    chk("cmd_size", {30'd0, mem_size}, {30'd0, c.size});
                    if (c.we) chk("cmd_wdata", mem_wdata, c.wdata);
                end
            end else if (f_gnt || d_gnt) begin
                n_tests++; n_fail++;
                $display("FAIL gnt_without_mem_req: f_gnt=%0b d_gnt=%0b, required mem_req=1", f_gnt, d_gnt);
            end
            if (f_gnt) last_f_gnt = cyc;
            if (f_rvalid) last_f_rv = cyc;
            if (d_rvalid) last_d_rv = cyc;
            if (f_rvalid || d_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_unexpected: f_rvalid=%0b d_rvalid=%0b, required none", f_rvalid, d_rvalid);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_port", {30'd0, f_rvalid, d_rvalid}, r.is_d ? 32'd1 : 32'd2);
                    if (r.is_d) chk("rsp_d_rdata", d_rdata, r.rdata);
                    else        chk("rsp_f_rdata", f_rdata, r.rdata);
                end
            end
        end
    endtask

    task automatic wait_gnt(input bit is_d);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(is_d ? d_gnt : f_gnt) && k < 20);
        if (!(is_d ? d_gnt : f_gnt)) begin
            n_tests++; n_fail++;
            $display("FAIL gnt_timeout: got no %s in 20 cycles, required a grant", is_d ? "d_gnt" : "f_gnt");
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || model_busy) && k < 60) begin
            @(negedge clock);
            k++;
        end
        if (k >= 60) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d commands / %0d responses pending, required 0",
                     exp_cmd.size(), exp_rsp.size());
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {24'd0, mem_req, mem_we, mem_size, f_gnt, d_gnt, f_rvalid, d_rvalid}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_f_rdata"}, f_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        int c0;
        int dcnt;
        int k;

        fork
            monitor();
        join_none

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // Fetch only, L=1: grant at +1, completion at +3
        mem_lat = 1;
        c0 = cyc;
        f_addr = 32'h0100_0000;
        f_req = 1'b1;
        exp_fetch(32'h0100_0000);
        wait_gnt(1'b0);
        f_req = 1'b0;
        drain();
        chk("fetch_gnt_latency", 32'(last_f_gnt - c0), 32'd1);
        chk("fetch_rvalid_latency", 32'(last_f_rv - c0), 32'd3);

        // Fetch and data load together: data first, fetch right after d_rvalid
        mem_lat = 2;
        f_addr = 32'h0100_0004; f_req = 1'b1;
        d_addr = 32'h0100_0100; d_we = 1'b0; d_size = 2'b10; d_wdata = 32'd0; d_req = 1'b1;
        exp_data(1'b0, 32'h0100_0100, 32'd0, 2'b10, 1'b1);
        exp_fetch(32'h0100_0004);
        k = 0;
        while ((f_req || d_req) && k < 40) begin
            @(negedge clock);
            k++;
            if (d_gnt) d_req = 1'b0;
            if (f_gnt) f_req = 1'b0;
        end
        drain();
        chk("fetch_after_d_rvalid", 32'(last_f_gnt - last_d_rv), 32'd1);

        // Byte store: command fields forwarded, d_rdata untouched
        mem_lat = 1;
        d_addr = 32'h0100_0200; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_size = 2'b00; d_req = 1'b1;
        exp_data(1'b1, 32'h0100_0200, 32'hDEAD_BEEF, 2'b00, 1'b1);
        wait_gnt(1'b1);
        d_req = 1'b0; d_we = 1'b0;
        drain();
        chk("store_keeps_d_rdata", d_rdata, exp_d_rdata);

        // Half-word load with L=2
        mem_lat = 2;
        d_addr = 32'h0100_0302; d_size = 2'b01; d_req = 1'b1;
        exp_data(1'b0, 32'h0100_0302, 32'd0, 2'b01, 1'b1);
        wait_gnt(1'b1);
        d_req = 1'b0;
        drain();

        // Both requesters held continuously
        mem_lat = 1;
        d_addr = 32'h0100_0400; d_we = 1'b0; d_size = 2'b10; d_req = 1'b1;
        f_addr = 32'h0100_0008; f_req = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) exp_data(1'b0, 32'h0100_0400, 32'd0, 2'b10, 1'b1);
        exp_fetch(32'h0100_0008);
        exp_data(1'b0, 32'h0100_0400, 32'd0, 2'b10, 1'b1);
`else
        for (int i = 0; i < 5; i++) exp_data(1'b0, 32'h0100_0400, 32'd0, 2'b10, 1'b1);
        exp_fetch(32'h0100_0008);
`endif
        dcnt = 0;
        k = 0;
        while ((d_req || f_req) && k < 200) begin
            @(negedge clock);
            k++;
            if (d_gnt) begin
                dcnt++;
                if (dcnt == 5) d_req = 1'b0;
            end
            if (f_gnt) f_req = 1'b0;
        end
        if (d_req || f_req) begin
            n_tests++; n_fail++;
            $display("FAIL contention_timeout: got %0d data grants, required 5 plus one fetch", dcnt);
            d_req = 1'b0; f_req = 1'b0;
        end
        drain();

        // Spurious mem_rvalid in IDLE
        spur_rdata = 32'hBAD0_BAD0;
        spur_rvalid = 1'b1;
        @(negedge clock);
        spur_rvalid = 1'b0;
        chk("spurious_no_rvalid_0", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        @(negedge clock);
        chk("spurious_no_rvalid_1", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        chk("spurious_f_rdata_held", f_rdata, exp_f_rdata);
        chk("spurious_d_rdata_held", d_rdata, exp_d_rdata);

        // Reset during BUSY_D, memory answers after release
        mem_lat = 3;
        d_addr = 32'h0100_0500; d_we = 1'b0; d_size = 2'b10; d_req = 1'b1;
        exp_data(1'b0, 32'h0100_0500, 32'd0, 2'b10, 1'b0);
        wait_gnt(1'b1);
        d_req = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_f_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        check_zero("midreset");
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("late_rvalid_ignored", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        end
        check_zero("after_late_rvalid");
        drain();

        // Arbiter is idle again and serves a new fetch
        mem_lat = 1;
        f_addr = 32'h0100_0010; f_req = 1'b1;
        exp_fetch(32'h0100_0010);
        wait_gnt(1'b0);
        f_req = 1'b0;
        drain();

        // Request held through reset is granted right after release
        f_addr = 32'h0100_0014; f_req = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        c0 = cyc;
        exp_fetch(32'h0100_0014);
        wait_gnt(1'b0);
        f_req = 1'b0;
        drain();
        chk("req_held_in_reset", 32'(last_f_gnt - c0), 32'd1);

        chk("scoreboard_empty", 32'(exp_cmd.size() + exp_rsp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
